// File: rtl/cgf_pkg.sv
// Shared types and helpers for the candidate generator/filter.
// Holds the FSM encoding, default LFSR constants and the Galois step function.
package cgf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        CHECK,
        EMIT,
        DONE
    } state_t;

    localparam logic [31:0] CGF_POLY = 32'h8020_0003;
    localparam logic [31:0] CGF_SEED = 32'h0000_0001;

    // Galois right-shift step: a set LSB folds the feedback mask back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur, input logic [31:0] poly);
        return cur[0] ? ((cur >> 1) ^ poly) : (cur >> 1);
    endfunction

endpackage

// File: rtl/cgf_lfsr32.sv
// 32-bit Galois LFSR that advances only when step is high.
// Exposes the low OUT_W bits as the candidate value.
module cgf_lfsr32
    import cgf_pkg::*;
#(
    parameter logic [31:0] SEED  = CGF_SEED,
    parameter logic [31:0] POLY  = CGF_POLY,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [OUT_W-1:0] value
);

    // An all-zero state would lock up the register, so a zero seed becomes 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = step ? lfsr_step(lfsr_q, POLY) : lfsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED_EFF;
        else     lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/cand_gen_filter.sv
// Drives LFSR candidates to the constraint modules and forwards only those
// satisfying every constraint over a valid/ready handshake, giving up after MAX_TRIES.
module cand_gen_filter
    import cgf_pkg::*;
#(
    parameter int          VAR_W     = 16,
    parameter int          NUM_CONS  = 4,
    parameter logic [31:0] SEED      = CGF_SEED,
    parameter logic [31:0] POLY      = CGF_POLY,
    parameter int          MAX_TRIES = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_samples,
    output logic [VAR_W-1:0]    cand,
    input  logic [NUM_CONS-1:0] cons_ok,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [VAR_W-1:0]    sample_data,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [CNT_W-1:0]    accept_cnt,
    output logic [CNT_W-1:0]    try_cnt
);

    localparam logic [31:0] MAX_TRIES_U = 32'(MAX_TRIES);

    state_t             state_q, state_d;
    logic               sample_valid_q, sample_valid_d;
    logic [VAR_W-1:0]   sample_data_q, sample_data_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;
    logic [CNT_W-1:0]   try_cnt_q, try_cnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   accept_inc;
    logic               all_ok, tries_out, handshake;

    cgf_lfsr32 #(
        .SEED  (SEED),
        .POLY  (POLY),
        .OUT_W (VAR_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (state_q == GEN),
        .value (cand)
    );

    assign all_ok     = &cons_ok;
    assign tries_out  = 32'(try_cnt_q) >= MAX_TRIES_U;
    assign handshake  = sample_valid_q && sample_ready;
    assign accept_inc = accept_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (num_samples == '0) ? DONE : GEN;
            GEN:        state_d = CHECK;
            CHECK:      state_d = all_ok ? EMIT : (tries_out ? DONE : GEN);
            EMIT:       if (handshake) state_d = (accept_inc == target_q) ? DONE : GEN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_valid_d = sample_valid_q;
        sample_data_d  = sample_data_q;
        done_d         = done_q;
        fail_d         = fail_q;
        accept_cnt_d   = accept_cnt_q;
        try_cnt_d      = try_cnt_q;
        target_d       = target_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d     = num_samples;
                    accept_cnt_d = '0;
                    try_cnt_d    = '0;
                    fail_d       = 1'b0;
                    done_d       = (num_samples == '0);
                end
            end
            GEN: begin
                if (try_cnt_q != '1) try_cnt_d = try_cnt_q + 1'b1;
            end
            CHECK: begin
                if (all_ok) begin
                    sample_data_d  = cand;
                    sample_valid_d = 1'b1;
                end else if (tries_out) begin
                    fail_d = 1'b1;
                    done_d = 1'b1;
                end
            end
            EMIT: begin
                if (handshake) begin
                    accept_cnt_d   = accept_inc;
                    try_cnt_d      = '0;
                    sample_valid_d = 1'b0;
                    if (accept_inc == target_q) done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
            accept_cnt_q   <= '0;
            try_cnt_q      <= '0;
            target_q       <= '0;
        end else begin
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            done_q         <= done_d;
            fail_q         <= fail_d;
            accept_cnt_q   <= accept_cnt_d;
            try_cnt_q      <= try_cnt_d;
            target_q       <= target_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign accept_cnt   = accept_cnt_q;
    assign try_cnt      = try_cnt_q;
    assign busy         = (state_q == GEN) || (state_q == CHECK) || (state_q == EMIT);

endmodule
